// File: rtl/output_comp_pkg.sv
// Shared types and constants for the packet-buffer read side (output_comp).
// Slot base address is pktID << SLOT_SHIFT: 32 flits per 2 KB slot.
package output_comp_pkg;

  localparam int unsigned PKT_AWIDTH    = 6;
  localparam int unsigned SLOT_SHIFT    = 5;
  localparam int unsigned PKTBUF_AWIDTH = PKT_AWIDTH + SLOT_SHIFT;
  localparam int unsigned RD_LAT        = 2;
  localparam int unsigned FIFO_DEPTH    = 8;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
    logic [511:0] data;
  } flit_t;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFree} state_e;

  function automatic logic [PKTBUF_AWIDTH-1:0] slot_addr(input logic [PKT_AWIDTH-1:0] pkt_id,
                                                         input logic [4:0]            idx);
    // idx <= 31, so the add never carries into the next slot
    return (PKTBUF_AWIDTH'(pkt_id) << SLOT_SHIFT) + PKTBUF_AWIDTH'(idx);
  endfunction

endpackage

// File: rtl/output_comp_if.sv
// Descriptor, packet-buffer, egress stream and emptylist signals of output_comp.
// master = surrounding system, slave = output_comp.
interface output_comp_if;
  import output_comp_pkg::*;

  logic                     desc_valid;
  logic [PKT_AWIDTH-1:0]    desc_pktID;
  logic [4:0]               desc_flits;
  logic                     desc_drop;
  logic                     desc_ready;

  logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
  logic                     pkt_buffer_read;
  flit_t                    pkt_buffer_readdata;

  logic                     out_sop;
  logic                     out_eop;
  logic [511:0]             out_data;
  logic [5:0]               out_empty;
  logic                     out_valid;
  logic                     out_ready;

  logic [PKT_AWIDTH-1:0]    emptylist_in_data;
  logic                     emptylist_in_valid;
  logic                     emptylist_in_ready;

  logic                     err_flag;

  modport master (
    output desc_valid, desc_pktID, desc_flits, desc_drop,
    input  desc_ready,
    input  pkt_buffer_address, pkt_buffer_read,
    output pkt_buffer_readdata,
    input  out_sop, out_eop, out_data, out_empty, out_valid,
    output out_ready,
    input  emptylist_in_data, emptylist_in_valid,
    output emptylist_in_ready,
    input  err_flag
  );

  modport slave (
    input  desc_valid, desc_pktID, desc_flits, desc_drop,
    output desc_ready,
    output pkt_buffer_address, pkt_buffer_read,
    input  pkt_buffer_readdata,
    output out_sop, out_eop, out_data, out_empty, out_valid,
    input  out_ready,
    output emptylist_in_data, emptylist_in_valid,
    input  emptylist_in_ready,
    output err_flag
  );

endinterface

// File: rtl/output_comp_fifo.sv
// Show-ahead synchronous FIFO of flits with occupancy count and async reset.
// Depth must be a power of two so the pointers wrap naturally.
module output_comp_fifo import output_comp_pkg::*; #(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  flit_t                  i_data,
  input  logic                   i_pop,
  output flit_t                  o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(Depth):0] o_count
);

  localparam int unsigned AW = $clog2(Depth);

  flit_t         r_mem [Depth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (AW + 1)'(Depth));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so push-while-full is legal then
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW + 1)'(w_do_push) - (AW + 1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/output_comp.sv
// Reads a forwarded packet from the packet buffer, streams it out, frees its pktID.
// Define OUTPUT_COMP_CHECK_EN to enable the sticky sop/eop framing check (err_flag).
module output_comp import output_comp_pkg::*; #(
  parameter int unsigned RdLat     = RD_LAT,
  parameter int unsigned FifoDepth = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  output_comp_if.slave  bus
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  state_e                r_state;
  state_e                w_state_d;
  logic [PKT_AWIDTH-1:0] r_pkt_id;
  logic [5:0]            r_flits;
  logic [4:0]            r_idx;
  logic [5:0]            r_pop_cnt;
  logic [RdLat-1:0]      r_vld;
  logic [CntW-1:0]       r_outstanding;

  logic                  w_accept;
  logic                  w_rd;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_credit;
  logic                  w_last_rd;
  logic                  w_last_pop;
  logic [CntW-1:0]       w_count;
  flit_t                 w_head;

  assign w_accept   = bus.desc_valid & bus.desc_ready;
  assign w_push     = r_vld[RdLat-1];
  assign w_pop      = ~w_empty & bus.out_ready;
  // Reads in flight plus stored flits may never exceed the FIFO depth
  assign w_credit   = ~w_full &
                      (({1'b0, r_outstanding} + {1'b0, w_count}) < (CntW + 1)'(FifoDepth));
  assign w_last_rd  = ({1'b0, r_idx} == (r_flits - 6'd1));
  assign w_last_pop = w_pop & (r_pop_cnt == (r_flits - 6'd1));

  always_comb begin
    w_state_d = r_state;
    w_rd      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.desc_valid) begin
          w_state_d = bus.desc_drop ? StFree : StRead;
        end
      end
      StRead: begin
        if (w_credit) begin
          w_rd = 1'b1;
          if (w_last_rd) begin
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (w_last_pop) begin
          w_state_d = StFree;
        end
      end
      StFree: begin
        if (bus.emptylist_in_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_pkt_id      <= '0;
      r_flits       <= '0;
      r_idx         <= '0;
      r_pop_cnt     <= '0;
      r_vld         <= '0;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_d;
      r_vld         <= RdLat'({r_vld, w_rd});
      r_outstanding <= r_outstanding + CntW'(w_rd) - CntW'(w_push);
      if (w_accept) begin
        r_pkt_id  <= bus.desc_pktID;
        r_flits   <= (bus.desc_flits == 5'd0) ? 6'd32 : {1'b0, bus.desc_flits};
        r_idx     <= '0;
        r_pop_cnt <= '0;
      end else begin
        if (w_rd) begin
          r_idx <= r_idx + 5'd1;
        end
        if (w_pop) begin
          r_pop_cnt <= r_pop_cnt + 6'd1;
        end
      end
    end
  end

  output_comp_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.pkt_buffer_readdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // desc_ready is held low while reset is asserted even though the state is idle
  assign bus.desc_ready         = (r_state == StIdle) & ~rst;
  assign bus.pkt_buffer_read    = w_rd;
  assign bus.pkt_buffer_address = slot_addr(r_pkt_id, r_idx);

  assign bus.out_valid = ~w_empty;
  assign bus.out_sop   = w_head.sop;
  assign bus.out_eop   = w_head.eop;
  assign bus.out_empty = w_head.empty;
  assign bus.out_data  = w_head.data;

  assign bus.emptylist_in_valid = (r_state == StFree);
  assign bus.emptylist_in_data  = r_pkt_id;

`ifdef OUTPUT_COMP_CHECK_EN
  logic [5:0] r_push_idx;
  logic       r_err;
  logic       w_bad;

  assign w_bad = w_push &
                 ((bus.pkt_buffer_readdata.sop != (r_push_idx == 6'd0)) |
                  (bus.pkt_buffer_readdata.eop != (r_push_idx == (r_flits - 6'd1))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_push_idx <= '0;
      end else if (w_push) begin
        r_push_idx <= r_push_idx + 6'd1;
      end
      r_err <= r_err | w_bad;
    end
  end

  assign bus.err_flag = r_err;
`else
  assign bus.err_flag = 1'b0;
`endif

endmodule

// File: doc/output_comp.md
Name: output_comp

Overview:
- Read-side counterpart of the packet-buffer writer. Takes a forwarding descriptor (pktID, flit count, drop flag) and reads that packet's flits from the packet buffer.
- Streams the flits out on an Ethernet-style sop/eop/empty interface with backpressure.
- Returns the freed pktID to the packet emptylist.
- Sits between the scheduler/forwarding stage and the egress MAC.

Parameters:
- PKTBUF_AWIDTH, package value, packet-buffer flit address width.
- PKT_AWIDTH, package value, pktID width; slot base address = pktID << 5 (32 flits per 2 KB slot).
- RD_LAT, 2, fixed packet-buffer read latency in cycles.
- FIFO_DEPTH, 8, output flit FIFO depth (power of 2, >= RD_LAT+2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- desc_valid  in  1  descriptor valid
- desc_pktID  in  PKT_AWIDTH  packet slot ID
- desc_flits  in  5  flit count; 0 encodes 32
- desc_drop  in  1  free the slot without transmitting
- desc_ready  out  1  descriptor accepted when valid&ready
- pkt_buffer_address  out  PKTBUF_AWIDTH  read address
- pkt_buffer_read  out  1  read strobe
- pkt_buffer_readdata  in  flit_t  {sop,eop,empty[5:0],data[511:0]}, valid RD_LAT cycles after read
- out_sop, out_eop  out  1  stream framing
- out_data  out  512  flit data
- out_empty  out  6  empty bytes in eop flit
- out_valid  out  1  flit valid
- out_ready  in  1  sink ready
- emptylist_in_data  out  PKT_AWIDTH  pktID being freed
- emptylist_in_valid  out  1  free request
- emptylist_in_ready  in  1  emptylist accepts
- err_flag  out  1  sticky framing error

Behaviour:
- Reset (async): FSM=IDLE; desc_ready, pkt_buffer_read, out_valid, emptylist_in_valid, err_flag = 0; FIFO empty; credit/outstanding counters 0; read-pipe valid shift register cleared. Any packet in flight at reset is lost; its pktID is not returned.
- FSM states:
  - IDLE:
    - desc_ready=1.
    - On accept: latch pktID and flits (0→32); idx=0.
    - drop=1 → FREE; else → READ.
  - READ:
    - Issue a read when outstanding + FIFO occupancy < FIFO_DEPTH.
    - address = (pktID<<5) + idx, computed in PKTBUF_AWIDTH bits; idx++.
    - After the read with idx == flits-1 → DRAIN.
  - DRAIN: wait until the FIFO pops the packet's last flit (out_valid&out_ready&out_eop) → FREE.
  - FREE: emptylist_in_valid=1, data=pktID; hold until emptylist_in_ready → IDLE.
  - desc_ready=0 in every state except IDLE.
- Read pipeline:
  - An RD_LAT-deep valid shift register tracks outstanding reads.
  - The returned flit is pushed into the FIFO at the same cycle readdata is valid.
  - Credit rule guarantees the FIFO never overflows; push and pop in the same cycle are allowed and net zero.
- Output:
  - FIFO head drives out_* combinationally; out_valid = !fifo_empty.
  - Pop on out_valid & out_ready.
  - out_valid must stay high and out_* stable while out_ready=0.
- Throughput: one flit/cycle sustained with out_ready=1. First flit appears RD_LAT+1 cycles after descriptor accept.
- Single flit (flits=1): one read, sop=eop=1 passes through unchanged.
- flits=0: 32 reads, address wraps within the slot only; no carry into the next slot because idx ≤ 31.

Optional Feature:
OUTPUT_COMP_CHECK_EN
- Defined:
  - On FIFO push, check that the flit with idx 0 has sop=1, the last flit has eop=1, and no other flit has sop or eop set.
  - A violation sets err_flag (sticky until reset). Data still passes through unchanged.
- Undefined: err_flag tied 0; no check logic.

Decomposition:
- flit_t, PKT_AWIDTH, PKTBUF_AWIDTH and the slot shift constant (5) live in the shared struct package.
- One sub-module: output_comp_fifo, a synchronous FIFO of flit_t with show-ahead read, full/empty, occupancy count and async reset.

Test Plan:
- Desc {pktID=3, flits=4, drop=0}, buffer preloaded, out_ready=1 → reads at 96..99; 4 flits out back-to-back, sop on first, eop+empty on 4th; then emptylist_in_data=3 valid for one cycle.
- Desc {pktID=5, flits=1} → one read at 160; single flit with sop=eop=1, out_empty=20 matches stored value; pktID 5 freed.
- Desc {pktID=7, flits=0} → 32 reads at 224..255; 32 flits out; pktID 7 freed once.
- Desc {pktID=2, drop=1} → no pkt_buffer_read; emptylist_in_valid with data 2; hold emptylist_in_ready=0 for 3 cycles → valid stays high and desc_ready stays 0 until accepted.
- flits=10, out_ready toggling 1-of-3 cycles → FIFO occupancy never exceeds 8, no flit lost or duplicated, out_* stable while stalled.
- Assert rst mid-READ → outputs 0 immediately. With OUTPUT_COMP_CHECK_EN, a preloaded middle flit with eop=1 sets err_flag and it stays set.
